// File: rtl/mem_seq.sv
// -----------------------------------------------------------------------------
// mem_seq
//   Sequencer for the 256x8 MEMORY block (address register AR plus a RAM with
//   synchronous read). Takes one load/store request at a time, direct or
//   indirect (the pointer is held in RAM), and produces the AR load and RAM
//   strobes with the correct read timing. Load data comes back on a one-cycle
//   response pulse. This block is the only driver of the MEMORY control pins.
//
//   Optional feature macro: MEMSEQ_AR_REUSE_EN
//     When defined, a shadow copy of AR (ar_sh_q/ar_vld_q) is kept. A direct
//     request whose address equals the shadow skips the AR load state.
//
// Ports
//   clk, rst_n          clock (posedge), asynchronous active-low reset
//   req_valid/ready     request handshake
//   req_op              00 LD dir, 01 LD ind, 10 ST dir, 11 ST ind
//   req_addr, req_wdata direct address or pointer location, store data
//   resp_valid          one-cycle completion pulse
//   resp_rdata          last load data, held until the next load completes
//   busy                sequencer not idle
//   mem_addr/srcA/wAR/wM/R  MEMORY control and data outputs
//   mem_M               RAM read data (valid one cycle after AR)
//   dbg_state           current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_seq #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_srcA,
    output logic          mem_wAR,
    output logic          mem_wM,
    output logic [DW-1:0] mem_R,
    input  logic [DW-1:0] mem_M,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETA, S_PWAIT, S_PSET, S_RWAIT, S_RCAP, S_WR, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          xfer;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high. req_ready is high only in IDLE; while busy the
    // requester keeps its request stable and it is simply not taken.
    assign xfer = req_valid && (state_q == S_IDLE);

`ifdef MEMSEQ_AR_REUSE_EN
    logic [AW-1:0] ar_sh_q;
    logic          ar_vld_q;
    logic          reuse_hit;

    // Only direct requests may reuse AR; indirect ones must fetch the pointer.
    assign reuse_hit = !req_op[0] && ar_vld_q && (req_addr == ar_sh_q);

    // Mirrors every AR load this block performs, so it tracks AR exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_sh_q  <= '0;
            ar_vld_q <= 1'b0;
        end else if (mem_wAR) begin
            ar_sh_q  <= mem_srcA ? AW'(mem_M) : addr_q;
            ar_vld_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // RAM data for the final address is on mem_M during RCAP.
            if (state_q == S_RCAP) begin
                rdata_q <= mem_M;
            end
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_wAR    = 1'b0;
        mem_srcA   = 1'b0;
        mem_wM     = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = S_SETA;
`ifdef MEMSEQ_AR_REUSE_EN
                    if (reuse_hit) begin
                        state_d = req_op[1] ? S_WR : S_RWAIT;
                    end
`endif
                end
            end
            S_SETA: begin
                mem_wAR = 1'b1;
                if (op_q[0]) begin
                    state_d = S_PWAIT;
                end else begin
                    state_d = op_q[1] ? S_WR : S_RWAIT;
                end
            end
            S_PWAIT: state_d = S_PSET;
            S_PSET: begin
                // AR takes the pointer straight from the RAM output.
                mem_wAR  = 1'b1;
                mem_srcA = 1'b1;
                state_d  = op_q[1] ? S_WR : S_RWAIT;
            end
            S_RWAIT: state_d = S_RCAP;
            S_RCAP:  state_d = S_DONE;
            S_WR: begin
                mem_wM  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign resp_rdata = rdata_q;
    assign mem_addr   = addr_q;
    assign mem_R      = wdata_q;
    assign dbg_state  = state_q;

endmodule
